// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MIPS MEM stage: valid/ready request,
// programmable wait states and a one-cycle response pulse with error flag.
module data_memory_ctrl #(
   parameter int unsigned MEMORY_DEPTH = 256,
   parameter logic [31:0] BASE_ADDR    = 32'h10010000,
   parameter int unsigned WAIT_STATES  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         r_state;
   logic [3:0]     r_cnt;
   logic           r_write;
   logic           r_unsigned;
   logic           r_err;
   logic [1:0]     r_size;
   logic [1:0]     r_lane;
   logic [AW-1:0]  r_idx;
   logic [31:0]    r_wdata;
   logic [31:0]    r_mem [MEMORY_DEPTH];

   logic [31:0]    w_offset;
   logic           w_req_err;
   logic           w_sel_in;
   logic           w_cur_write;
   logic           w_cur_unsigned;
   logic           w_cur_err;
   logic [1:0]     w_cur_size;
   logic [1:0]     w_cur_lane;
   logic [AW-1:0]  w_cur_idx;
   logic [31:0]    w_cur_wdata;
   logic           w_to_resp;
   logic           w_commit;
   logic [3:0]     w_be;
   logic [31:0]    w_wlane;
   logic [31:0]    w_word;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;
   logic [31:0]    w_load;
   logic [31:0]    w_rdata_next;

   assign w_offset  = req_addr - BASE_ADDR;
   assign w_req_err = (req_addr < BASE_ADDR)
                   || ({2'b00, w_offset[31:2]} >= 32'(MEMORY_DEPTH))
                   || (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   // With zero wait states the commit edge is the accept edge, so the
   // request is taken straight from the ports instead of the latches.
   assign w_sel_in       = (r_state == S_IDLE);
   assign w_cur_write    = w_sel_in ? req_write         : r_write;
   assign w_cur_unsigned = w_sel_in ? req_unsigned      : r_unsigned;
   assign w_cur_err      = w_sel_in ? w_req_err         : r_err;
   assign w_cur_size     = w_sel_in ? req_size          : r_size;
   assign w_cur_lane     = w_sel_in ? w_offset[1:0]     : r_lane;
   assign w_cur_idx      = w_sel_in ? w_offset[AW+1:2]  : r_idx;
   assign w_cur_wdata    = w_sel_in ? req_wdata         : r_wdata;

   assign w_to_resp = ((r_state == S_IDLE) && req_valid && (WAIT_STATES == 0))
                   || ((r_state == S_WAIT) && (r_cnt == '0));
   assign w_commit  = w_to_resp && !w_cur_err && !reset;

   always_comb begin
      w_be    = '0;
      w_wlane = '0;
      case (w_cur_size)
         2'b00: begin
            w_be    = 4'b0001 << w_cur_lane;
            w_wlane = {4{w_cur_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_cur_lane[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{w_cur_wdata[15:0]}};
         end
         2'b10: begin
            w_be    = '1;
            w_wlane = w_cur_wdata;
         end
         default: ;
      endcase
   end

   assign w_word = r_mem[w_cur_idx];
   assign w_byte = w_word[{w_cur_lane, 3'b000} +: 8];
   assign w_half = w_cur_lane[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_load = '0;
      case (w_cur_size)
         2'b00:   w_load = w_cur_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = w_cur_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         2'b10:   w_load = w_word;
         default: w_load = '0;
      endcase
   end

   assign w_rdata_next = (w_cur_err || w_cur_write) ? '0 : w_load;

   always_ff @(posedge clk) begin
      if (w_commit && w_cur_write) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_cur_idx][8*i +: 8] <= w_wlane[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
         r_cnt      <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write    <= req_write;
                  r_unsigned <= req_unsigned;
                  r_err      <= w_req_err;
                  r_size     <= req_size;
                  r_lane     <= w_offset[1:0];
                  r_idx      <= w_offset[AW+1:2];
                  r_wdata    <= req_wdata;
                  req_ready  <= 1'b0;
                  if (WAIT_STATES > 0) begin
                     r_state <= S_WAIT;
                     r_cnt   <= 4'(WAIT_STATES - 1);
                  end else begin
                     r_state    <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= w_rdata_next;
                     resp_error <= w_cur_err;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= w_rdata_next;
                  resp_error <= w_cur_err;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               r_state   <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: three instances with 2, 0 and 3
// wait states share one clock and one queue of expected responses.
module tb_data_memory_ctrl;

   typedef struct {
      int          inst;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst  [3];
   logic        rv   [3];
   logic        rdy  [3];
   logic        wr   [3];
   logic        uns  [3];
   logic [1:0]  sz   [3];
   logic [31:0] ad   [3];
   logic [31:0] wd   [3];
   logic        rsv  [3];
   logic [31:0] rd   [3];
   logic        rerr [3];

   int unsigned ws_of [3] = '{2, 0, 3};
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_resp [3] = '{0, 0, 0};
   exp_t        sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_ctrl #(.MEMORY_DEPTH(256), .BASE_ADDR(32'h10010000), .WAIT_STATES(2)) u_dut0 (
      .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(wr[0]),
      .req_size(sz[0]), .req_unsigned(uns[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
      .resp_valid(rsv[0]), .resp_rdata(rd[0]), .resp_error(rerr[0]));

   data_memory_ctrl #(.MEMORY_DEPTH(256), .BASE_ADDR(32'h10010000), .WAIT_STATES(0)) u_dut1 (
      .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(wr[1]),
      .req_size(sz[1]), .req_unsigned(uns[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
      .resp_valid(rsv[1]), .resp_rdata(rd[1]), .resp_error(rerr[1]));

   data_memory_ctrl #(.MEMORY_DEPTH(256), .BASE_ADDR(32'h10010000), .WAIT_STATES(3)) u_dut2 (
      .clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_write(wr[2]),
      .req_size(sz[2]), .req_unsigned(uns[2]), .req_addr(ad[2]), .req_wdata(wd[2]),
      .resp_valid(rsv[2]), .resp_rdata(rd[2]), .resp_error(rerr[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rsv[i] === 1'b1) begin
            n_resp[i]++;
            if (sb.size() == 0) begin
               check("spurious_resp", 32'(sb.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("resp_inst",  i,       e.inst);
               check("resp_rdata", rd[i],   e.rdata);
               check("resp_error", {31'h0, rerr[i]}, {31'h0, e.err});
               check("resp_cycle", cyc,     e.cyc);
            end
         end
      end
   end

   // Called #1 after a rising edge with the instance idle.
   task automatic do_req(input int i, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      check("ready_idle", {31'h0, rdy[i]}, 32'd1);
      rv[i] = 1'b1; wr[i] = w; sz[i] = s; uns[i] = u; ad[i] = a; wd[i] = d;
      e.inst = i; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + 1 + int'(ws_of[i]);
      sb.push_back(e);
      @(posedge clk); #1;
      rv[i] = 1'b0;
      for (int k = 0; k <= int'(ws_of[i]); k++) begin
         check("busy_ready", {31'h0, rdy[i]}, 32'd0);
         @(posedge clk); #1;
      end
      check("resp_seen", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int c0;
      int base_n;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; rv[i] = 1'b0; wr[i] = 1'b0; uns[i] = 1'b0;
         sz[i] = 2'b00; ad[i] = '0; wd[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_ready", {31'h0, rdy[i]},  32'd1);
         check("rst_valid", {31'h0, rsv[i]},  32'd0);
         check("rst_rdata", rd[i],            32'd0);
         check("rst_error", {31'h0, rerr[i]}, 32'd0);
         rst[i] = 1'b0;
      end
      @(posedge clk); #1;

      // WAIT_STATES=2: stores, loads, extension and error cases
      do_req(0, 1, 2'b10, 0, 32'h10010004, 32'hDEADBEEF, 32'h0, 0);
      do_req(0, 0, 2'b10, 0, 32'h10010004, 32'h0,        32'hDEADBEEF, 0);
      do_req(0, 1, 2'b00, 0, 32'h10010005, 32'h123456A5, 32'h0, 0);
      do_req(0, 0, 2'b10, 0, 32'h10010004, 32'h0,        32'hDEADA5EF, 0);
      do_req(0, 0, 2'b00, 0, 32'h10010005, 32'h0,        32'hFFFFFFA5, 0);
      do_req(0, 0, 2'b00, 1, 32'h10010005, 32'h0,        32'h000000A5, 0);
      do_req(0, 0, 2'b01, 0, 32'h10010006, 32'h0,        32'hFFFFDEAD, 0);
      do_req(0, 0, 2'b01, 1, 32'h10010006, 32'h0,        32'h0000DEAD, 0);
      do_req(0, 1, 2'b01, 0, 32'h10010004, 32'h00007F01, 32'h0, 0);
      do_req(0, 0, 2'b10, 0, 32'h10010004, 32'h0,        32'hDEAD7F01, 0);
      do_req(0, 0, 2'b10, 0, 32'h10010002, 32'h0,        32'h0, 1);
      do_req(0, 0, 2'b01, 0, 32'h10010001, 32'h0,        32'h0, 1);
      do_req(0, 0, 2'b11, 0, 32'h10010004, 32'h0,        32'h0, 1);
      do_req(0, 0, 2'b10, 0, 32'h10010400, 32'h0,        32'h0, 1);
      do_req(0, 1, 2'b10, 0, 32'h1000FFFC, 32'h55555555, 32'h0, 1);
      do_req(0, 1, 2'b10, 0, 32'h10010006, 32'h99999999, 32'h0, 1);
      do_req(0, 1, 2'b00, 0, 32'h10010003, 32'h00000077, 32'h0, 0);
      do_req(0, 0, 2'b10, 0, 32'h10010004, 32'h0,        32'hDEAD7F01, 0);
      do_req(0, 0, 2'b00, 1, 32'h10010003, 32'h0,        32'h00000077, 0);

      // WAIT_STATES=0: req_valid held for 6 cycles, accepts on every other edge
      c0 = cyc;
      base_n = n_resp[1];
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.inst = 1; e.rdata = 32'h0; e.err = 1'b0; e.cyc = c0 + 1 + 2 * k;
         sb.push_back(e);
      end
      for (int k = 0; k < 6; k++) begin
         rv[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'b10; uns[1] = 1'b0;
         ad[1] = 32'h10010000 + 32'(4 * k);
         wd[1] = 32'hA0000000 + 32'(k);
         @(posedge clk); #1;
      end
      rv[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("ws0_accepts", n_resp[1] - base_n, 32'd3);
      check("ws0_drained", 32'(sb.size()), 32'd0);
      do_req(1, 0, 2'b10, 0, 32'h10010008, 32'h0, 32'hA0000002, 0);
      do_req(1, 0, 2'b10, 0, 32'h10010010, 32'h0, 32'hA0000004, 0);
      do_req(1, 0, 2'b00, 0, 32'h10010013, 32'h0, 32'hFFFFFFA0, 0);

      // WAIT_STATES=3: reset during WAIT aborts the store
      do_req(2, 1, 2'b10, 0, 32'h10010008, 32'h11111111, 32'h0, 0);
      base_n = n_resp[2];
      rv[2] = 1'b1; wr[2] = 1'b1; sz[2] = 2'b10; uns[2] = 1'b0;
      ad[2] = 32'h10010008; wd[2] = 32'hCAFEF00D;
      @(posedge clk); #1;
      rv[2] = 1'b0;
      check("abort_busy", {31'h0, rdy[2]}, 32'd0);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      check("abort_ready", {31'h0, rdy[2]}, 32'd1);
      check("abort_valid", {31'h0, rsv[2]}, 32'd0);
      repeat (6) begin @(posedge clk); #1; end
      check("abort_no_resp", n_resp[2] - base_n, 32'd0);
      do_req(2, 0, 2'b10, 0, 32'h10010008, 32'h0, 32'h11111111, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-addressable data memory for the MIPS processor with a valid/ready request interface and a one-cycle response pulse.
- Supports byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Programmable wait states model slower memory.
- Flags misaligned, illegal-size and out-of-range accesses.
- Sits between the MEM stage / stall logic and the data segment starting at BASE_ADDR.

Parameters:
- MEMORY_DEPTH, 256, number of 32-bit words.
- BASE_ADDR, 32'h10010000, byte address of word 0.
- WAIT_STATES, 0, extra cycles between accept and commit; legal range 0..15.
- Data width is fixed at 32; byte lanes are little-endian.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse, response complete.
- resp_rdata  out  32  load result, extended to 32 bits.
- resp_error  out  1  access rejected; qualified by resp_valid.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock.
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch write, size, unsigned, addr, wdata and the error flag. Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else RESP.
  - WAIT: req_ready=0. Decrement counter; go to RESP when counter==0.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE. There is no response backpressure.
- Latency: resp_valid is high exactly WAIT_STATES+1 cycles after the accept edge.
- Throughput: one request per WAIT_STATES+2 cycles.
- Offset computation: offset = req_addr - BASE_ADDR (32-bit unsigned subtract). Word index = offset[31:2]; lane = offset[1:0].
- Error (computed at accept) is true when any of:
  - req_addr < BASE_ADDR;
  - offset[31:2] >= MEMORY_DEPTH;
  - req_size==11;
  - halfword with addr[0]!=0;
  - word with addr[1:0]!=0.
- Commit happens on the edge entering RESP, and only when no error and reset is low.
  - Store byte writes wdata[7:0] to lane addr[1:0].
  - Store halfword writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Store word writes all four lanes.
  - Other lanes are untouched.
- Load data is captured on the same edge into resp_rdata.
  - The selected lane(s) are right-justified.
  - The upper bits are zero-filled when req_unsigned=1, else sign-extended from bit 7 or bit 15.
  - Word loads ignore req_unsigned.
- Stores: resp_rdata=0 on the response.
- Error response: resp_error=1, resp_rdata=0, no RAM write.
- resp_rdata and resp_error hold their values until the next response or reset. resp_error is cleared to 0 on every error-free response.
- req_valid held high while not in IDLE is ignored. No request is accepted twice and none is queued.
- Reset mid-operation (WAIT or RESP) aborts the request: no commit, no resp_valid, req_ready=1 on the following cycle.
- Inputs other than req_valid are don't-care outside the accept cycle.

Test Plan:
- WAIT_STATES=2, reset, sw addr 0x10010004 data 0xDEADBEEF accepted at cycle 0 -> resp_valid only at cycle 3, req_ready=0 cycles 1-3, resp_error=0; then lw 0x10010004 -> resp_rdata=0xDEADBEEF.
- After the above, sb 0x10010005 data 0x123456A5 -> lw 0x10010004 returns 0xDEADA5EF; lb 0x10010005 returns 0xFFFFFFA5; lbu returns 0x000000A5.
- lh 0x10010006 -> 0xFFFFDEAD; lhu -> 0x0000DEAD; sh 0x10010004 data 0x00007F01 then lw -> 0xDEAD7F01.
- lw 0x10010002, lh 0x10010001, req_size=11, lw 0x10010400, sw 0x1000FFFC -> each gives resp_error=1, resp_rdata=0; lw 0x10010004 afterwards still returns 0xDEAD7F01.
- WAIT_STATES=0, req_valid held high for 6 cycles with sw requests -> exactly 3 accepts, resp_valid at cycles 1, 3, 5.
- WAIT_STATES=3, sw 0x10010008 data 0xCAFEF00D, reset asserted during WAIT -> no resp_valid, req_ready=1 the cycle after reset; lw 0x10010008 does not return 0xCAFEF00D (prior contents are unchanged).
